// File: rtl/vga_sprite_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_sprite_engine
//
// N-sprite pixel generator placed between the VGA timing counters and the RGB
// output stage. Each sprite is a SPR_W x SPR_H rectangle. The engine keeps a
// position and a direction per sprite and updates them once per frame. Sprites
// move either manually (buttons, wrapping at the screen edges) or autonomously
// (bouncing off the screen edges). For every pixel the engine produces a
// registered RGB value in which the lowest-numbered sprite wins where sprites
// overlap.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   h_counter    current pixel column
//   v_counter    current line
//   v_sync       vertical sync (clk domain); its rising edge marks a new frame
//   sel          per-sprite move enable
//   btn_l/r/u/d  level move requests, active-high
//   fast         1 = move STEP_FAST pixels per frame, 0 = STEP_SLOW
//   bounce_mode  0 = manual wrap mode, 1 = autonomous bounce mode
//   spr_color    sprite i colour {r,g,b} in bits [24i+23:24i]
//   red/green/blue  registered pixel colour
//   hit          registered per-sprite coverage of the current pixel
//   frame_tick   one-cycle pulse on the detected v_sync rising edge
// -----------------------------------------------------------------------------
module vga_sprite_engine #(
    parameter int          NUM_SPRITES = 4,
    parameter int          H_ACTIVE    = 1280,
    parameter int          V_ACTIVE    = 720,
    parameter int          SPR_W       = 64,
    parameter int          SPR_H       = 64,
    parameter int          STEP_SLOW   = 2,
    parameter int          STEP_FAST   = 6,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [11:0]                h_counter,
    input  logic [11:0]                v_counter,
    input  logic                       v_sync,
    input  logic [NUM_SPRITES-1:0]     sel,
    input  logic                       btn_l,
    input  logic                       btn_r,
    input  logic                       btn_u,
    input  logic                       btn_d,
    input  logic                       fast,
    input  logic                       bounce_mode,
    input  logic [24*NUM_SPRITES-1:0]  spr_color,
    output logic [7:0]                 red,
    output logic [7:0]                 green,
    output logic [7:0]                 blue,
    output logic [NUM_SPRITES-1:0]     hit,
    output logic                       frame_tick
);

    // The initial layout places sprites along the diagonal, so they must all fit.
    if (NUM_SPRITES < 1 || NUM_SPRITES > 8) begin : g_bad_count
        $error("vga_sprite_engine: NUM_SPRITES must be in 1..8");
    end
    if (NUM_SPRITES * SPR_W > H_ACTIVE || NUM_SPRITES * SPR_H > V_ACTIVE) begin : g_bad_layout
        $error("vga_sprite_engine: initial sprite layout does not fit the active area");
    end

    // Largest legal top-left coordinate; candidates are 13-bit signed so that
    // a step below zero is visible as a negative value.
    localparam logic signed [12:0] XMAX_C      = 13'(H_ACTIVE - SPR_W);
    localparam logic signed [12:0] YMAX_C      = 13'(V_ACTIVE - SPR_H);
    localparam logic signed [12:0] STEP_SLOW_C = 13'(STEP_SLOW);
    localparam logic signed [12:0] STEP_FAST_C = 13'(STEP_FAST);
    localparam logic [12:0]        SPR_W_C     = 13'(SPR_W);
    localparam logic [12:0]        SPR_H_C     = 13'(SPR_H);
    localparam logic [12:0]        H_ACTIVE_C  = 13'(H_ACTIVE);
    localparam logic [12:0]        V_ACTIVE_C  = 13'(V_ACTIVE);

    // Bounce one axis: returns {dir_neg, pos}. Hitting an edge clamps the
    // position onto the edge and reverses the direction.
    function automatic logic [12:0] bounce_axis(
        input logic [11:0]        pos,
        input logic               neg,
        input logic signed [12:0] step,
        input logic signed [12:0] lim
    );
        logic signed [12:0] cand;
        logic [12:0]        res;
        cand = $signed({1'b0, pos}) + (neg ? -step : step);
        if (cand > lim) begin
            res = {1'b1, lim[11:0]};
        end else if (cand < 13'sd0) begin
            res = {1'b0, 12'd0};
        end else begin
            res = {neg, cand[11:0]};
        end
        return res;
    endfunction

    // Manual move of one axis: inc/dec pressed together cancel out, and
    // leaving the legal range wraps to the opposite edge.
    function automatic logic [11:0] manual_axis(
        input logic [11:0]        pos,
        input logic               inc,
        input logic               dec,
        input logic signed [12:0] step,
        input logic signed [12:0] lim
    );
        logic signed [12:0] cand;
        logic [11:0]        res;
        if (inc && !dec) begin
            cand = $signed({1'b0, pos}) + step;
        end else if (dec && !inc) begin
            cand = $signed({1'b0, pos}) - step;
        end else begin
            cand = $signed({1'b0, pos});
        end
        if (cand > lim) begin
            res = 12'd0;
        end else if (cand < 13'sd0) begin
            res = lim[11:0];
        end else begin
            res = cand[11:0];
        end
        return res;
    endfunction

    logic [11:0]             x_r         [NUM_SPRITES];
    logic [11:0]             y_r         [NUM_SPRITES];
    logic                    dir_x_neg_r [NUM_SPRITES];
    logic                    dir_y_neg_r [NUM_SPRITES];
    logic [11:0]             x_nxt_s     [NUM_SPRITES];
    logic [11:0]             y_nxt_s     [NUM_SPRITES];
    logic                    dir_x_nxt_s [NUM_SPRITES];
    logic                    dir_y_nxt_s [NUM_SPRITES];
    logic signed [12:0]      step_s;
    logic                    v_sync_d_r;
    logic [NUM_SPRITES-1:0]  in_s;
    logic [23:0]             rgb_s;

    // Frame edge detector: one-cycle tick on the v_sync rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sync_d_r <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            v_sync_d_r <= v_sync;
            frame_tick <= v_sync & ~v_sync_d_r;
        end
    end

    // Next sprite positions/directions, applied only in the frame_tick cycle.
    always_comb begin
        step_s = fast ? STEP_FAST_C : STEP_SLOW_C;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            x_nxt_s[i]     = x_r[i];
            y_nxt_s[i]     = y_r[i];
            dir_x_nxt_s[i] = dir_x_neg_r[i];
            dir_y_nxt_s[i] = dir_y_neg_r[i];
            if (sel[i]) begin
                if (bounce_mode) begin
                    {dir_x_nxt_s[i], x_nxt_s[i]} =
                        bounce_axis(x_r[i], dir_x_neg_r[i], step_s, XMAX_C);
                    {dir_y_nxt_s[i], y_nxt_s[i]} =
                        bounce_axis(y_r[i], dir_y_neg_r[i], step_s, YMAX_C);
                end else begin
                    // Manual moves leave the bounce direction untouched so a
                    // later switch back to bounce resumes where it was.
                    x_nxt_s[i] = manual_axis(x_r[i], btn_r, btn_l, step_s, XMAX_C);
                    y_nxt_s[i] = manual_axis(y_r[i], btn_d, btn_u, step_s, YMAX_C);
                end
            end else begin
                x_nxt_s[i]     = x_r[i];
                y_nxt_s[i]     = y_r[i];
                dir_x_nxt_s[i] = dir_x_neg_r[i];
                dir_y_nxt_s[i] = dir_y_neg_r[i];
            end
        end
    end

    // Sprite state registers; reset lays the sprites out along the diagonal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_r[i]         <= 12'(i * SPR_W);
                y_r[i]         <= 12'(i * SPR_H);
                dir_x_neg_r[i] <= 1'b0;
                dir_y_neg_r[i] <= 1'b0;
            end
        end else if (frame_tick) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_r[i]         <= x_nxt_s[i];
                y_r[i]         <= y_nxt_s[i];
                dir_x_neg_r[i] <= dir_x_nxt_s[i];
                dir_y_neg_r[i] <= dir_y_nxt_s[i];
            end
        end
    end

    // Per-sprite coverage of the current pixel (left/top edges inclusive).
    always_comb begin
        in_s = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            in_s[i] = ({1'b0, h_counter} >= {1'b0, x_r[i]}) &&
                      ({1'b0, h_counter} <  ({1'b0, x_r[i]} + SPR_W_C)) &&
                      ({1'b0, v_counter} >= {1'b0, y_r[i]}) &&
                      ({1'b0, v_counter} <  ({1'b0, y_r[i]} + SPR_H_C));
        end
    end

    // Colour select: blank outside the active area, otherwise the lowest
    // covering sprite, otherwise background. Scanning downwards lets the
    // lowest index overwrite any higher one.
    always_comb begin
        rgb_s = BG_COLOR;
        if (({1'b0, h_counter} >= H_ACTIVE_C) || ({1'b0, v_counter} >= V_ACTIVE_C)) begin
            rgb_s = 24'h000000;
        end else begin
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                rgb_s = in_s[i] ? spr_color[24*i +: 24] : rgb_s;
            end
        end
    end

    // Output registers: one clock of latency from the pixel counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= 8'd0;
            green <= 8'd0;
            blue  <= 8'd0;
            hit   <= '0;
        end else begin
            {red, green, blue} <= rgb_s;
            hit                <= in_s;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
`timescale 1ns/1ps
// Self-checking bench for vga_sprite_engine. A behavioural model tracks sprite
// positions; each probed pixel pushes its expected colour/coverage into a
// scoreboard queue that is popped when the registered output appears.
module tb_vga_sprite_engine;

    localparam int NS   = 4;
    localparam int HA   = 1280;
    localparam int VA   = 720;
    localparam int W    = 64;
    localparam int H    = 64;
    localparam int XMAX = HA - W;
    localparam int YMAX = VA - H;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   h_counter, v_counter;
    logic          v_sync;
    logic [NS-1:0] sel;
    logic          btn_l, btn_r, btn_u, btn_d, fast, bounce_mode;
    logic [24*NS-1:0] spr_color;
    logic [7:0]    red, green, blue;
    logic [NS-1:0] hit;
    logic          frame_tick;

    logic [23:0] col [NS] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00};
    assign spr_color = {col[3], col[2], col[1], col[0]};

    vga_sprite_engine dut (
        .clk(clk), .rst(rst), .h_counter(h_counter), .v_counter(v_counter),
        .v_sync(v_sync), .sel(sel), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u),
        .btn_d(btn_d), .fast(fast), .bounce_mode(bounce_mode), .spr_color(spr_color),
        .red(red), .green(green), .blue(blue), .hit(hit), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mx [NS], my [NS], mdx [NS], mdy [NS];
    logic [23:0]   exp_rgb_q [$];
    logic [NS-1:0] exp_hit_q [$];

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mx[i] = i * W; my[i] = i * H; mdx[i] = 1; mdy[i] = 1;
        end
    endtask

    task automatic model_frame();
        int s, cx, cy;
        s = fast ? 6 : 2;
        for (int i = 0; i < NS; i++) begin
            if (sel[i]) begin
                if (bounce_mode) begin
                    cx = mx[i] + mdx[i] * s;
                    if (cx > XMAX) begin mx[i] = XMAX; mdx[i] = -1; end
                    else if (cx < 0) begin mx[i] = 0; mdx[i] = 1; end
                    else mx[i] = cx;
                    cy = my[i] + mdy[i] * s;
                    if (cy > YMAX) begin my[i] = YMAX; mdy[i] = -1; end
                    else if (cy < 0) begin my[i] = 0; mdy[i] = 1; end
                    else my[i] = cy;
                end else begin
                    cx = mx[i] + ((btn_r && !btn_l) ? s : ((btn_l && !btn_r) ? -s : 0));
                    if (cx > XMAX) cx = 0; else if (cx < 0) cx = XMAX;
                    mx[i] = cx;
                    cy = my[i] + ((btn_d && !btn_u) ? s : ((btn_u && !btn_d) ? -s : 0));
                    if (cy > YMAX) cy = 0; else if (cy < 0) cy = YMAX;
                    my[i] = cy;
                end
            end
        end
    endtask

    task automatic expect_pixel(input int h, input int v,
                                output logic [23:0] er, output logic [NS-1:0] eh);
        eh = '0;
        for (int i = 0; i < NS; i++)
            if (h >= mx[i] && h < mx[i] + W && v >= my[i] && v < my[i] + H) eh[i] = 1'b1;
        if (h >= HA || v >= VA) er = 24'h000000;
        else begin
            er = 24'h000000;
            for (int i = NS - 1; i >= 0; i--) if (eh[i]) er = col[i];
        end
    endtask

    // Drive one pixel, push its expectation, compare one clock later.
    task automatic probe(input int h_in, input int v_in);
        int h, v;
        logic [23:0] er, got;
        logic [NS-1:0] eh;
        h = (h_in < 0) ? h_in + 4096 : h_in;
        v = (v_in < 0) ? v_in + 4096 : v_in;
        @(negedge clk);
        h_counter = 12'(h); v_counter = 12'(v);
        expect_pixel(h, v, er, eh);
        exp_rgb_q.push_back(er); exp_hit_q.push_back(eh);
        @(posedge clk); #1;
        er = exp_rgb_q.pop_front(); eh = exp_hit_q.pop_front();
        got = {red, green, blue};
        checks++;
        if (got !== er) begin
            errors++;
            $display("FAIL pixel_rgb (%0d,%0d): got %h expected %h", h, v, got, er);
        end
        checks++;
        if (hit !== eh) begin
            errors++;
            $display("FAIL pixel_hit (%0d,%0d): got %b expected %b", h, v, hit, eh);
        end
    endtask

    task automatic probe_sprite(input int i);
        probe(mx[i], my[i]);
        probe(mx[i] - 1, my[i]);
        probe(mx[i] + W - 1, my[i] + H - 1);
        probe(mx[i] + W, my[i] + H - 1);
        probe(mx[i], my[i] + H);
        probe(mx[i] + 3, my[i] - 1);
    endtask

    // One v_sync rising edge; the DUT moves sprites at the end of the tick cycle.
    task automatic frame();
        @(negedge clk); v_sync = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL frame_tick_rise: got %b expected 1", frame_tick);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL frame_tick_pulse: got %b expected 0", frame_tick);
        end
        model_frame();
        @(negedge clk); v_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; v_sync = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_buttons();
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); h_counter = 12'd64; v_counter = 12'd64; v_sync = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({red, green, blue} !== 24'h000000) begin
            errors++; $display("FAIL reset_rgb: got %h expected 000000", {red, green, blue});
        end
        checks++;
        if (hit !== 4'b0000) begin
            errors++; $display("FAIL reset_hit: got %b expected 0000", hit);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick);
        end
        v_sync = 1'b0; rst = 1'b0;
        model_reset();
        probe(64, 64);
        probe(0, 0);
        probe(63, 63);
        probe(1279, 719);
        probe_sprite(3);
    endtask

    task automatic test_priority();
        apply_reset();
        bounce_mode = 1'b0; fast = 1'b1;
        sel = 4'b0100; clear_buttons(); btn_l = 1'b1; btn_u = 1'b1;
        repeat (5) frame();
        sel = 4'b0001; clear_buttons(); btn_r = 1'b1; btn_d = 1'b1;
        repeat (7) frame();
        clear_buttons();
        probe(100, 100);
        probe(1280, 5);
        probe(5, 720);
        probe(99, 99);
        probe(160, 160);
        probe(300, 300);
    endtask

    task automatic test_manual_wrap();
        apply_reset();
        bounce_mode = 1'b0; sel = 4'b0001; clear_buttons();
        btn_l = 1'b1; fast = 1'b0;
        frame(); probe_sprite(0);
        frame(); probe_sprite(0);
        btn_l = 1'b0; btn_r = 1'b1; fast = 1'b1;
        frame(); probe_sprite(0);
        btn_r = 1'b0; btn_l = 1'b1; fast = 1'b0;
        frame(); probe_sprite(0);
        btn_l = 1'b0; btn_u = 1'b1;
        frame(); probe_sprite(0);
        btn_u = 1'b0; btn_d = 1'b1; fast = 1'b1;
        frame(); probe_sprite(0);
        sel = 4'b0000; clear_buttons(); btn_r = 1'b1;
        frame(); probe_sprite(0); probe_sprite(1);
        clear_buttons();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bounce_mode = 1'b0; sel = 4'b1111; fast = 1'b1;
        btn_l = 1'b1; btn_r = 1'b1; btn_u = 1'b1; btn_d = 1'b1;
        repeat (3) frame();
        for (int i = 0; i < NS; i++) probe_sprite(i);
        clear_buttons(); btn_r = 1'b1; btn_d = 1'b1;
        repeat (40) @(negedge clk);
        probe_sprite(1);
        clear_buttons();
    endtask

    task automatic test_bounce();
        int pdx0, pdy0, pdx1, pdy1;
        apply_reset();
        bounce_mode = 1'b0; sel = 4'b0001; clear_buttons();
        btn_l = 1'b1; fast = 1'b0;
        repeat (3) frame();
        probe_sprite(0);
        btn_l = 1'b0; bounce_mode = 1'b1; fast = 1'b1;
        frame(); probe_sprite(0);
        frame(); probe_sprite(0);
        sel = 4'b0011; btn_r = 1'b1; btn_u = 1'b1;
        for (int f = 0; f < 250; f++) begin
            pdx0 = mdx[0]; pdy0 = mdy[0]; pdx1 = mdx[1]; pdy1 = mdy[1];
            frame();
            if (pdx0 != mdx[0] || pdy0 != mdy[0] || (f % 50) == 0) probe_sprite(0);
            if (pdx1 != mdx[1] || pdy1 != mdy[1]) probe_sprite(1);
        end
        bounce_mode = 1'b0; clear_buttons();
        frame(); probe_sprite(0);
        bounce_mode = 1'b1;
        frame(); probe_sprite(0); probe_sprite(1);
        clear_buttons();
    endtask

    task automatic test_async_reset();
        probe(mx[0] + 1, my[0] + 1);
        @(negedge clk); v_sync = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL async_pre_tick: got %b expected 1", frame_tick);
        end
        checks++;
        if ({red, green, blue} !== col[0]) begin
            errors++; $display("FAIL async_pre_rgb: got %h expected %h", {red, green, blue}, col[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({red, green, blue} !== 24'h000000) begin
            errors++; $display("FAIL async_rgb: got %h expected 000000", {red, green, blue});
        end
        checks++;
        if (hit !== 4'b0000) begin
            errors++; $display("FAIL async_hit: got %b expected 0000", hit);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL async_tick: got %b expected 0", frame_tick);
        end
        @(negedge clk); v_sync = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int i = 0; i < NS; i++) probe_sprite(i);
    endtask

    initial begin
        rst = 1'b1; h_counter = 12'd0; v_counter = 12'd0; v_sync = 1'b0;
        sel = '0; fast = 1'b0; bounce_mode = 1'b0;
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
        model_reset();
        test_reset();
        test_priority();
        test_manual_wrap();
        test_simultaneous();
        test_bounce();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
